// File: rtl/alu_operand_seq.sv
// alu_operand_seq
// Upstream sequencer for the ALU operand/opcode load registers.
// It collects a byte stream (A, B, opcode) over valid/ready. It issues one-cycle
// load strobes together with a shared load bus. After ALU_LAT cycles it captures
// the ALU result and flags, then holds them for a downstream valid/ready consumer.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_data/in_valid/in_ready        byte input handshake (in_ready is combinational)
//   abort                            synchronous abandon of the current transaction
//   ld_a/ld_b/ld_op/ld_bus           registered load strobes and shared load data
//   alu_result/alu_flags             ALU output {C,Z,N,V}, sampled at capture
//   res_valid/res_ready              result handshake
//   res_data/res_flags               captured result and flags
//   busy                             high whenever not waiting for operand A
//   txn_count                        completed (consumed) transactions, wraps at 256
module alu_operand_seq #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_op,
    output logic [WIDTH-1:0] ld_bus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags,
    output logic             busy,
    output logic [7:0]       txn_count
);

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       w_get;
    logic       w_xfer;
    logic       w_capture;
    logic       w_consume;

    assign w_get     = (r_state == S_GET_A) || (r_state == S_GET_B) || (r_state == S_GET_OP);
    assign in_ready  = w_get && !abort;
    assign w_xfer    = in_valid && in_ready;
    // abort suppresses capture and consume so that it wins over both
    assign w_capture = (r_state == S_WAIT) && (r_cnt == 4'd0) && !abort;
    assign w_consume = (r_state == S_RESULT) && res_ready && !abort;

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_GET_A;
        end else begin
            case (r_state)
                S_GET_A:  if (w_xfer)    w_next = S_GET_B;
                S_GET_B:  if (w_xfer)    w_next = S_GET_OP;
                S_GET_OP: if (w_xfer)    w_next = S_WAIT;
                S_WAIT:   if (w_capture) w_next = S_RESULT;
                S_RESULT: if (w_consume) w_next = S_GET_A;
                default:                 w_next = S_GET_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_GET_A;
            busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next != S_GET_A);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_a      <= 1'b0;
            ld_b      <= 1'b0;
            ld_op     <= 1'b0;
            ld_bus    <= '0;
            r_cnt     <= 4'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= 4'd0;
            txn_count <= 8'd0;
        end else begin
            // w_xfer already excludes abort, so strobes clear on abort
            ld_a  <= w_xfer && (r_state == S_GET_A);
            ld_b  <= w_xfer && (r_state == S_GET_B);
            ld_op <= w_xfer && (r_state == S_GET_OP);
            if (w_xfer)
                ld_bus <= in_data;

            if (w_xfer && (r_state == S_GET_OP))
                r_cnt <= LAT;
            else if ((r_state == S_WAIT) && (r_cnt != 4'd0) && !abort)
                r_cnt <= r_cnt - 4'd1;

            if (abort) begin
                res_valid <= 1'b0;
            end else if (w_capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_result;
                res_flags <= alu_flags;
            end else if (w_consume) begin
                res_valid <= 1'b0;
                txn_count <= txn_count + 8'd1;
            end
        end
    end

endmodule
